// File: rtl/keycode_history_display.sv
// keycode_history_display
//
// Captures PS/2 scan codes (single-cycle code_valid pulses), keeps a shift
// history of the last DIGITS/2 codes and drives a DIGITS-wide multiplexed
// common-anode 7-segment display. Break sequences (F0 plus the following
// code) can optionally be discarded.
//
// Ports:
//   clk100Mhz  - system clock, all state on the rising edge
//   reset      - asynchronous, active-high; clears all state
//   code_valid - one-cycle strobe; code is taken on every edge it is high
//   code[7:0]  - scan code byte, meaningful while code_valid is high
//   enable     - 0 blanks the display; history and scanning keep running
//   anodes     - active-low digit select, at most one bit low
//   segs[6:0]  - active-low segments {g,f,e,d,c,b,a}
//   decimalPt  - active-low decimal point
//   count[7:0] - accepted codes since reset, modulo 256
//
// Handshake: code_valid/code is a plain strobe with no back-pressure. Every
// rising edge that sees code_valid high is one event; the source must pulse.
module keycode_history_display #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int FILTER_BREAK = 1
) (
  input  logic              clk100Mhz,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [7:0]        code,
  input  logic              enable,
  output logic [DIGITS-1:0] anodes,
  output logic [6:0]        segs,
  output logic              decimalPt,
  output logic [7:0]        count
);

  localparam int HW     = 4 * DIGITS;
  localparam int NCODES = DIGITS / 2;
  localparam int FILL_W = $clog2(NCODES + 1);
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(DIGITS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BREAK = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hist_q, hist_d;
  logic [7:0]          count_q, count_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]          segs_q, segs_d;
  logic                dp_q, dp_d;

  logic                accept;
  logic                pre_tc;
  logic                lit;
  logic [3:0]          nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    // Break filter: F0 arms BREAK, the next strobe (whatever its value) is
    // swallowed and returns to IDLE.
    accept  = 1'b0;
    state_d = state_q;
    if (code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (FILTER_BREAK != 0 && code == 8'hF0) state_d = ST_BREAK;
          else                                    accept  = 1'b1;
        end
        ST_BREAK: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Newest code lands on digits 1:0; the oldest falls off the top.
    hist_d  = accept ? ((hist_q << 8) | HW'(code)) : hist_q;
    count_d = accept ? count_q + 8'd1 : count_q;
    fill_d  = (accept && fill_q != FILL_W'(NCODES)) ? fill_q + FILL_W'(1) : fill_q;

    // Scan timing is free-running and independent of enable and accepts.
    pre_tc = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d  = pre_tc ? '0 : pre_q + PRE_W'(1);
    idx_d  = idx_q;
    if (pre_tc) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    // Output registers sample the current digit, so pins lag by one cycle.
    nibble   = hist_q[{idx_q, 2'b00} +: 4];
    lit      = enable && ((int'(idx_q) / 2) < int'(fill_q));
    anodes_d = '1;
    segs_d   = 7'h7F;
    dp_d     = 1'b1;
    if (lit) begin
      anodes_d[idx_q] = 1'b0;
      segs_d          = hex7(nibble);
      // Point on the low digit of every code except the newest separates codes.
      dp_d            = !(idx_q[0] == 1'b0 && int'(idx_q) >= 2);
    end
  end

  always_ff @(posedge clk100Mhz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hist_q   <= '0;
      count_q  <= '0;
      fill_q   <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      anodes_q <= '1;
      segs_q   <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      count_q  <= count_d;
      fill_q   <= fill_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      anodes_q <= anodes_d;
      segs_q   <= segs_d;
      dp_q     <= dp_d;
    end
  end

  assign anodes    = anodes_q;
  assign segs      = segs_q;
  assign decimalPt = dp_q;
  assign count     = count_q;

endmodule

// File: tb/tb_keycode_history_display.sv
// Bench for keycode_history_display with DIGITS=4, SCAN_DIV=4. Two copies
// share the stimulus: dut_a filters break codes, dut_b accepts everything.
module tb_keycode_history_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       enable = 1'b1;

  logic [3:0] an_a, an_b;
  logic [6:0] sg_a, sg_b;
  logic       dp_a, dp_b;
  logic [7:0] cnt_a, cnt_b;

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  // Segment constants, active-low {g..a}
  localparam logic [6:0] S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001, SE = 7'b0000110, SX = 7'h7F;

  keycode_history_display #(.DIGITS(4), .SCAN_DIV(4), .FILTER_BREAK(1)) dut_a (
    .clk100Mhz(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .enable(enable), .anodes(an_a), .segs(sg_a), .decimalPt(dp_a), .count(cnt_a)
  );

  keycode_history_display #(.DIGITS(4), .SCAN_DIV(4), .FILTER_BREAK(0)) dut_b (
    .clk100Mhz(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .enable(enable), .anodes(an_b), .segs(sg_b), .decimalPt(dp_b), .count(cnt_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Edges since reset release; the lit digit after edge k is ((k-1)/4)%4.
  int cyc = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int passed = 0;
  logic [20:0] exp_q[$];      // {sel, count, anodes, segs, dp}
  string       name_q[$];
  logic [7:0]  cnt_exp_q[$];  // dut_a count after each accept
  logic [7:0]  prev_cnt = 8'h00;

  always @(negedge clk) begin : monitor
    logic [20:0] e;
    logic [19:0] act;
    logic [7:0]  ec;
    string       nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = e[20] ? {cnt_b, an_b, sg_b, dp_b} : {cnt_a, an_a, sg_a, dp_a};
      total++;
      if (act === e[19:0]) passed++;
      else $display("FAIL %s: got cnt=%h an=%b seg=%b dp=%b, want cnt=%h an=%b seg=%b dp=%b",
                    nm, act[19:12], act[11:8], act[7:1], act[0],
                    e[19:12], e[11:8], e[7:1], e[0]);
    end
    if (reset) begin
      prev_cnt = cnt_a;
    end else if (cnt_a !== prev_cnt) begin
      prev_cnt = cnt_a;
      total++;
      if (cnt_exp_q.size() == 0) begin
        $display("FAIL count_event: got unexpected count=%h, want no change", cnt_a);
      end else begin
        ec = cnt_exp_q.pop_front();
        if (cnt_a === ec) passed++;
        else $display("FAIL count_event: got %h, want %h", cnt_a, ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit sel, input string nm, input logic [7:0] c,
                     input logic [3:0] an, input logic [6:0] sg, input logic dp);
    exp_q.push_back({sel, c, an, sg, dp});
    name_q.push_back(nm);
  endtask

  task automatic pulse(input logic [7:0] c);
    code_valid = 1'b1;
    code       = c;
    step();
    code_valid = 1'b0;
  endtask

  function automatic int disp_idx();
    return (cyc == 0) ? -1 : ((cyc - 1) / 4) % 4;
  endfunction

  // Advance to the first cycle the pins show digit i.
  task automatic wait_disp(input int i);
    int prev;
    bit hit;
    prev = disp_idx();
    hit  = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      step();
      if (disp_idx() == i && prev != i) hit = 1'b1;
      prev = disp_idx();
    end
    if (!hit) begin
      total++;
      $display("FAIL wait_disp: got no scan slot, want idx %0d", i);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 reset = 1'b1;
    step();
    chk(A, "reset_a", 8'h00, 4'hF, SX, 1'b1);
    chk(B, "reset_b", 8'h00, 4'hF, SX, 1'b1);
    step();
    reset = 1'b0;

    // Empty history stays dark.
    for (int j = 0; j < 4; j++) begin
      repeat (16) step();
      chk(A, "empty", 8'h00, 4'hF, SX, 1'b1);
    end

    // Single code 1C, with 4-cycle dwell.
    cnt_exp_q.push_back(8'd1);
    pulse(8'h1C);
    wait_disp(0);
    chk(A, "single_d0", 8'd1, 4'b1110, SC, 1'b1);
    for (int j = 0; j < 3; j++) begin
      step();
      chk(A, "dwell_d0", 8'd1, 4'b1110, SC, 1'b1);
    end
    step();
    chk(A, "single_d1", 8'd1, 4'b1101, S1, 1'b1);
    wait_disp(2);
    chk(A, "single_d2_dark", 8'd1, 4'hF, SX, 1'b1);
    wait_disp(3);
    chk(A, "single_d3_dark", 8'd1, 4'hF, SX, 1'b1);

    // Second code: 1,C,3,2 with separator on digit 2.
    cnt_exp_q.push_back(8'd2);
    pulse(8'h32);
    wait_disp(0);
    chk(A, "hist_d0", 8'd2, 4'b1110, S2, 1'b1);
    wait_disp(1);
    chk(A, "hist_d1", 8'd2, 4'b1101, S3, 1'b1);
    wait_disp(2);
    chk(A, "hist_d2", 8'd2, 4'b1011, SC, 1'b0);
    chk(B, "hist_d2_b", 8'd2, 4'b1011, SC, 1'b0);
    wait_disp(3);
    chk(A, "hist_d3", 8'd2, 4'b0111, S1, 1'b1);

    // Third code shifts the oldest out: 3,2,A,5.
    cnt_exp_q.push_back(8'd3);
    pulse(8'hA5);
    wait_disp(0);
    chk(A, "shift_d0", 8'd3, 4'b1110, S5, 1'b1);
    wait_disp(1);
    chk(A, "shift_d1", 8'd3, 4'b1101, SA, 1'b1);
    wait_disp(2);
    chk(A, "shift_d2", 8'd3, 4'b1011, S2, 1'b0);
    wait_disp(3);
    chk(A, "shift_d3", 8'd3, 4'b0111, S3, 1'b1);

    // F0 puts dut_a into BREAK, then an asynchronous reset mid-scan.
    pulse(8'hF0);
    reset = 1'b1;
    chk(A, "async_reset_a", 8'h00, 4'hF, SX, 1'b1);
    chk(B, "async_reset_b", 8'h00, 4'hF, SX, 1'b1);
    step();
    chk(A, "held_reset_a", 8'h00, 4'hF, SX, 1'b1);
    reset = 1'b0;

    // Break sequence: dut_a keeps 1C and 32, dut_b keeps all four.
    cnt_exp_q.push_back(8'd1);
    pulse(8'h1C);
    pulse(8'hF0);
    pulse(8'h1C);
    cnt_exp_q.push_back(8'd2);
    pulse(8'h32);
    wait_disp(0);
    chk(A, "break_d0", 8'd2, 4'b1110, S2, 1'b1);
    wait_disp(1);
    chk(A, "break_d1", 8'd2, 4'b1101, S3, 1'b1);
    chk(B, "nofilt_d1", 8'd4, 4'b1101, S3, 1'b1);
    wait_disp(2);
    chk(B, "nofilt_d2", 8'd4, 4'b1011, SC, 1'b0);
    wait_disp(3);
    chk(A, "break_d3", 8'd2, 4'b0111, S1, 1'b1);
    chk(B, "nofilt_d3", 8'd4, 4'b0111, S1, 1'b1);

    // Enable: blank one cycle later, history keeps updating.
    wait_disp(0);
    chk(A, "pre_disable", 8'd2, 4'b1110, S2, 1'b1);
    enable = 1'b0;
    step();
    chk(A, "disabled", 8'd2, 4'hF, SX, 1'b1);
    cnt_exp_q.push_back(8'd3);
    pulse(8'h11);
    cnt_exp_q.push_back(8'd4);
    pulse(8'h22);
    wait_disp(2);
    chk(A, "disabled_d2", 8'd4, 4'hF, SX, 1'b1);
    wait_disp(1);
    chk(A, "disabled_d1", 8'd4, 4'hF, SX, 1'b1);
    enable = 1'b1;
    step();
    chk(A, "reenable_d1", 8'd4, 4'b1101, S2, 1'b1);
    wait_disp(2);
    chk(A, "reenable_d2", 8'd4, 4'b1011, S1, 1'b0);

    // 252 back-to-back accepts take dut_a from 4 to 256 -> 0.
    code_valid = 1'b1;
    for (int i = 0; i < 252; i++) begin
      if (i == 250)      code = 8'h9E;
      else if (i == 251) code = 8'h7B;
      else               code = 8'(i % 128);
      cnt_exp_q.push_back(8'(4 + i + 1));
      step();
    end
    code_valid = 1'b0;
    wait_disp(3);
    chk(A, "wrap_d3", 8'h00, 4'b0111, S9, 1'b1);
    chk(B, "wrap_d3_b", 8'h02, 4'b0111, S9, 1'b1);
    wait_disp(2);
    chk(A, "wrap_d2", 8'h00, 4'b1011, SE, 1'b0);
    wait_disp(0);
    chk(A, "wrap_d0", 8'h00, 4'b1110, SB, 1'b1);

    // Accept on the same edge the scan wraps from digit 3 to digit 0.
    for (int n = 0; n < 40; n++) begin
      if (cyc % 16 == 15) break;
      step();
    end
    cnt_exp_q.push_back(8'd1);
    code_valid = 1'b1;
    code       = 8'h4D;
    step();
    code_valid = 1'b0;
    chk(A, "simul_old_d3", 8'd1, 4'b0111, S9, 1'b1);
    step();
    chk(A, "simul_new_d0", 8'd1, 4'b1110, SD, 1'b1);

    repeat (3) step();
    total++;
    if (cnt_exp_q.size() == 0) passed++;
    else $display("FAIL count_queue: got %0d pending accepts, want 0", cnt_exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
